mem_dcache: RTL and testbench

MEM_DCACHE -- requirements
Module: mem_dcache

---
 rtl/mem_dcache.sv | 141 ++++++++++++++
 tb/tb_mem_dcache.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one 32-bit word per line.
// Optional hit/miss counters are enabled by defining MEM_DCACHE_STATS_EN.
module mem_dcache #(
  parameter int WIDTH_MEM = 4,
  parameter int WIDTH_IDX = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_val,
  input  logic [WIDTH_MEM-1:0] i_addr,
  input  logic [31:0]          i_data,
  input  logic                 i_we,
  input  logic                 i_kill,
  output logic [31:0]          o_data,
  output logic                 o_nack,
  output logic                 mem_o_req,
  output logic                 mem_o_we,
  output logic [WIDTH_MEM-1:0] mem_o_addr,
  output logic [31:0]          mem_o_data,
  input  logic [31:0]          mem_i_data,
  input  logic                 mem_i_ack,
`ifdef MEM_DCACHE_STATS_EN
  output logic [15:0]          o_hits,
  output logic [15:0]          o_misses,
`endif
  output logic [1:0]           o_state
);

  localparam int LINES     = 2 ** WIDTH_IDX;
  localparam int WIDTH_TAG = WIDTH_MEM - WIDTH_IDX;

  // Memory handshake: mem_o_req rises with the transaction's fields already valid; those
  // fields stay stable while mem_o_req=1 and mem_i_ack=0; a cycle with both high completes it.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]     line_val;
  logic [WIDTH_TAG-1:0] line_tag  [LINES];
  logic [31:0]          line_data [LINES];

  logic [WIDTH_IDX-1:0] req_idx, fill_idx;
  logic [WIDTH_TAG-1:0] req_tag, fill_tag;
  logic                 req_live, accept, hit;
  logic                 load_hit, load_miss, store, fill;

  assign req_idx  = i_addr[WIDTH_IDX-1:0];
  assign req_tag  = i_addr[WIDTH_MEM-1:WIDTH_IDX];
  assign fill_idx = mem_o_addr[WIDTH_IDX-1:0];
  assign fill_tag = mem_o_addr[WIDTH_MEM-1:WIDTH_IDX];

  assign req_live  = i_val & ~i_kill;
  assign accept    = req_live & (state == IDLE);
  assign hit       = line_val[req_idx] & (line_tag[req_idx] == req_tag);
  assign load_hit  = accept & ~i_we & hit;
  assign load_miss = accept & ~i_we & ~hit;
  assign store     = accept & i_we;
  assign fill      = (state == RD_MISS) & mem_i_ack;

  assign o_state = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load_miss)  state_nxt = RD_MISS;
        else if (store) state_nxt = WR_THRU;
      end
      RD_MISS, WR_THRU: begin
        if (mem_i_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  line_val <= '0;
    else if (fill) line_val[fill_idx] <= 1'b1;
  end

  // Tag/data storage is not reset; the valid bits alone gate hits.
  always_ff @(posedge i_clk) begin
    if (fill) begin
      line_tag[fill_idx]  <= fill_tag;
      line_data[fill_idx] <= mem_i_data;
    end else if (store && hit) begin
      line_data[req_idx] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data     <= '0;
      o_nack     <= 1'b0;
      mem_o_req  <= 1'b0;
      mem_o_we   <= 1'b0;
      mem_o_addr <= '0;
      mem_o_data <= '0;
    end else begin
      // A live request is replayed if the cache is busy or it is a load miss.
      o_nack <= req_live & ((state != IDLE) | (~i_we & ~hit));
      if (load_hit) o_data <= line_data[req_idx];
      if (state == IDLE) begin
        if (load_miss) begin
          mem_o_req  <= 1'b1;
          mem_o_we   <= 1'b0;
          mem_o_addr <= i_addr;
        end else if (store) begin
          mem_o_req  <= 1'b1;
          mem_o_we   <= 1'b1;
          mem_o_addr <= i_addr;
          mem_o_data <= i_data;
        end
      end else if (mem_i_ack) begin
        mem_o_req <= 1'b0;
      end
    end
  end

`ifdef MEM_DCACHE_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hits   <= '0;
      o_misses <= '0;
    end else begin
      if (load_hit && o_hits != 16'hFFFF)    o_hits   <= o_hits + 16'd1;
      if (load_miss && o_misses != 16'hFFFF) o_misses <= o_misses + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_dcache.sv
// Bench for mem_dcache: directed scenarios then random traffic against a line/memory model.
module tb_mem_dcache;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_val, i_we, i_kill;
  logic [3:0]  i_addr;
  logic [31:0] i_data;
  logic [31:0] o_data;
  logic        o_nack;
  logic        mem_o_req, mem_o_we;
  logic [3:0]  mem_o_addr;
  logic [31:0] mem_o_data, mem_i_data;
  logic        mem_i_ack;
  logic [1:0]  o_state;

  int total = 0;
  int bad   = 0;

  // Reference model: cache lines hold the full word address, memory is a plain array.
  logic        m_cv [4];
  logic [3:0]  m_ca [4];
  logic [31:0] m_cd [4];
  logic [31:0] mem  [16];
  logic        m_busy, m_rd;
  logic [3:0]  m_paddr;
  logic [31:0] m_pdata;
  logic        exp_nack;
  logic [31:0] exp_data;
  logic [31:0] exp_q[$];

  always #5 i_clk = ~i_clk;

  mem_dcache #(.WIDTH_MEM(4), .WIDTH_IDX(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_val(i_val), .i_addr(i_addr),
    .i_data(i_data), .i_we(i_we), .i_kill(i_kill), .o_data(o_data),
    .o_nack(o_nack), .mem_o_req(mem_o_req), .mem_o_we(mem_o_we),
    .mem_o_addr(mem_o_addr), .mem_o_data(mem_o_data), .mem_i_data(mem_i_data),
    .mem_i_ack(mem_i_ack), .o_state(o_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cv[i] = 1'b0;
    m_busy   = 1'b0;
    m_rd     = 1'b0;
    m_paddr  = '0;
    m_pdata  = '0;
    exp_nack = 1'b0;
    exp_data = '0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    check("nack", {31'b0, o_nack}, {31'b0, exp_nack});
    if (exp_q.size() > 0) check("load_data", o_data, exp_q.pop_front());
    check("data_hold", o_data, exp_data);
    check("req", {31'b0, mem_o_req}, {31'b0, m_busy});
    check("state_idle", {31'b0, (o_state == 2'd0)}, {31'b0, ~m_busy});
    if (m_busy) begin
      check("mem_addr", {28'b0, mem_o_addr}, {28'b0, m_paddr});
      check("mem_we", {31'b0, mem_o_we}, {31'b0, ~m_rd});
      if (!m_rd) check("mem_wdata", mem_o_data, m_pdata);
    end
  endtask

  // Called just after a falling edge: drive, advance the model, then check after the rising edge.
  task automatic step(input logic v, input logic we, input logic k, input logic [3:0] a,
                      input logic [31:0] d, input logic ack);
    logic was_busy, hit;
    int   idx;
    i_val      = v;
    i_we       = we;
    i_kill     = k;
    i_addr     = a;
    i_data     = d;
    mem_i_ack  = ack;
    mem_i_data = m_busy ? mem[m_paddr] : $urandom();
    was_busy   = m_busy;
    idx        = int'(a[1:0]);
    hit        = m_cv[idx] && (m_ca[idx] == a);
    exp_nack   = 1'b0;
    if (v && !k) begin
      if (was_busy) exp_nack = 1'b1;
      else if (we) begin
        if (hit) m_cd[idx] = d;
        m_busy = 1'b1; m_rd = 1'b0; m_paddr = a; m_pdata = d;
      end else if (hit) begin
        exp_data = m_cd[idx];
        exp_q.push_back(m_cd[idx]);
      end else begin
        exp_nack = 1'b1;
        m_busy = 1'b1; m_rd = 1'b1; m_paddr = a;
      end
    end
    if (was_busy && ack) begin
      if (m_rd) begin
        m_cv[int'(m_paddr[1:0])] = 1'b1;
        m_ca[int'(m_paddr[1:0])] = m_paddr;
        m_cd[int'(m_paddr[1:0])] = mem[m_paddr];
      end else begin
        mem[m_paddr] = m_pdata;
      end
      m_busy = 1'b0;
    end
    @(posedge i_clk);
    #1;
    check_outputs();
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_val = 1'b0; i_kill = 1'b0; mem_i_ack = 1'b0;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_req", {31'b0, mem_o_req}, 32'd0);
    check("rst_nack", {31'b0, o_nack}, 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_addr", {28'b0, mem_o_addr}, 32'd0);
    check("rst_state", {30'b0, o_state}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  initial begin
    i_rst_n = 1'b0; i_val = 1'b0; i_we = 1'b0; i_kill = 1'b0;
    i_addr = '0; i_data = '0; mem_i_ack = 1'b0; mem_i_data = '0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom();
    model_reset();
    @(negedge i_clk);
    do_reset();

    // Refill of 4'h5 then replayed load
    mem[5] = 32'hDEADBEEF;
    step(1, 0, 0, 4'h5, 0, 0);
    step(0, 0, 0, 4'h0, 0, 1);
    step(1, 0, 0, 4'h5, 0, 0);
    check("dir_deadbeef", o_data, 32'hDEADBEEF);
    // Store hit with write-through
    step(1, 1, 0, 4'h5, 32'h12345678, 0);
    step(0, 0, 0, 4'h0, 0, 1);
    step(1, 0, 0, 4'h5, 0, 0);
    check("dir_store_hit", o_data, 32'h12345678);
    check("dir_mem_written", mem[5], 32'h12345678);
    // Conflicting tag evicts
    step(1, 0, 0, 4'h1, 0, 0);
    step(0, 0, 0, 4'h0, 0, 1);
    step(1, 0, 0, 4'h5, 0, 0);
    check("dir_evict_nack", {31'b0, o_nack}, 32'd1);
    step(0, 0, 0, 4'h0, 0, 1);
    // Killed miss does nothing
    step(1, 0, 1, 4'h9, 0, 0);
    // Requests during a delayed refill are nacked
    step(1, 0, 0, 4'h2, 0, 0);
    for (int i = 0; i < 3; i++) step(1, $urandom_range(0, 1), 0, 4'($urandom_range(0, 15)), $urandom(), 0);
    step(0, 0, 0, 4'h0, 0, 1);
    // Reset in the middle of a refill
    step(1, 0, 0, 4'h6, 0, 0);
    do_reset();
    step(1, 0, 0, 4'h5, 0, 0);
    check("dir_post_reset_miss", {31'b0, o_nack}, 32'd1);
    step(0, 0, 0, 4'h0, 0, 1);

    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 2,
           4'($urandom_range(0, 15)), $urandom(), $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
